seq_comparator: RTL and testbench
=================================

Name: seq_comparator

Overview:
- Parametrised, multi-cycle magnitude comparator for integer operands. Successor to the 32-bit single-cycle compare unit.
- Scans the operands CHUNK bits per cycle from the MSB down and terminates early on the first differing chunk.
- Reports lt/zero/gt through a valid/ready handshake.
- Intended for the branch/compare path and the FPU integer-compare helpers, where area matters more than single-cycle latency.

Parameters:
- WIDTH, 32: operand width in bits. Must be a multiple of CHUNK.
- CHUNK, 8: bits examined per cycle. Must be at least 1 and at most WIDTH.
- NCHUNK, WIDTH/CHUNK: derived, not overridable. Number of scan steps.

Ports:
- clk  input  1  clock. All state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  operand request valid.
- in_ready  output  1  block can accept a request. High only in IDLE.
- A_in  input  WIDTH  operand A.
- B_in  input  WIDTH  operand B.
- mode  input  1  1 = unsigned compare, 0 = signed (two's complement) compare.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- lt  output  1  A < B.
- zero  output  1  A == B.
- gt  output  1  A > B.

Behaviour:
- Reset (synchronous, active-high): state = IDLE, chunk index = NCHUNK-1, out_valid = 0, lt = 0, zero = 0, gt = 0, in_ready = 1 on the following cycle.
- Reset takes priority over every other event, including mid-SCAN and a DONE result that has not been consumed. An in-flight operation is dropped silently.
- States: IDLE, SCAN, DONE.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid = 1: register A_in, B_in and mode, set chunk index = NCHUNK-1, go to SCAN.
- Sign handling: when captured mode = 0, invert bit WIDTH-1 of both captured operands at capture (offset-binary). From then on every comparison is unsigned.
- SCAN (one chunk per cycle, highest chunk first):
  - Compare chunk[idx] of A against chunk[idx] of B.
  - Chunk A < chunk B: lt = 1, zero = 0, gt = 0; out_valid = 1; go to DONE.
  - Chunk A > chunk B: gt = 1, lt = 0, zero = 0; out_valid = 1; go to DONE.
  - Chunks equal and idx = 0: zero = 1, lt = 0, gt = 0; out_valid = 1; go to DONE.
  - Chunks equal and idx > 0: idx decrements by 1; stay in SCAN.
  - in_ready = 0 and out_valid = 0 throughout.
- Latency: out_valid rises k edges after the accept edge.
  - k = 1 + (NCHUNK-1-j), where j is the highest chunk index that differs.
  - k = NCHUNK for equal operands.
  - Minimum latency is 1 and maximum is NCHUNK.
- DONE:
  - lt, zero, gt and out_valid stay stable until an edge with out_ready = 1.
  - On that edge: out_valid = 0 and go to IDLE. Flags keep their last value; they are don't-care while out_valid = 0.
  - in_ready = 0, so there is no overlap of consecutive operations. Throughput is one result per k+2 cycles with out_ready tied high.
- Inputs A_in, B_in and mode are ignored outside the accept edge. Changing them mid-SCAN does not affect the result.
- Exactly one of lt, zero, gt is 1 whenever out_valid = 1.
- No overflow output: the compare is direct magnitude, so there is no subtraction overflow.
- NCHUNK = 1 (CHUNK = WIDTH) degenerates to a registered single-step compare with latency 1.

Optional Feature:
- Macro: SEQ_CMP_MINMAX_EN.
- Defined:
  - Adds outputs out_min and out_max, both WIDTH wide.
  - Valid with out_valid; hold the original, un-biased captured A or B.
  - out_min = A and out_max = B if lt = 1 or zero = 1; otherwise swapped.
  - Both reset to 0.
- Undefined: ports absent; no operand copies kept beyond those needed for the scan.

Test Plan:
1. WIDTH=32, CHUNK=8. A=5, B=5, mode=1, out_ready=1 -> out_valid 4 cycles after accept; zero=1, lt=0, gt=0.
2. A=0x8000_0000, B=0x0000_0001, mode=0 -> lt=1 at latency 1. Same operands, mode=1 -> gt=1 at latency 1.
3. A=0x0000_1200, B=0x0000_1300, mode=1 -> lt=1 at latency 3. A=0xFFFF_FFFF, B=0xFFFF_FFFE, mode=0 -> gt=1 (-1 > -2) at latency 4.
4. Back-pressure: result ready, out_ready held low 5 cycles -> out_valid=1, flags stable, in_ready=0. out_ready=1 -> IDLE next cycle; a new request is then accepted.
5. Reset mid-SCAN: rst=1 on the 2nd SCAN cycle of case 1 -> next cycle out_valid=0, all flags 0, in_ready=1, and no stale result afterwards. Also: A_in/B_in changed mid-SCAN -> result unaffected.
6. WIDTH=64, CHUNK=16, and WIDTH=32, CHUNK=32, with randomized signed/unsigned operands -> flags match a reference comparison and latency matches the formula. With SEQ_CMP_MINMAX_EN, out_min/out_max are correct.

Source files
------------

// File: rtl/seq_comparator.sv
// Multi-cycle magnitude comparator: scans operands CHUNK bits per cycle from the MSB and stops
// at the first differing chunk. Define SEQ_CMP_MINMAX_EN to add the out_min/out_max outputs.
module seq_comparator #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             lt,
  output logic             zero,
  output logic             gt
`ifdef SEQ_CMP_MINMAX_EN
  ,
  output logic [WIDTH-1:0] out_min,
  output logic [WIDTH-1:0] out_max
`endif
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IdxW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NCHUNK - 1);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e           state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             lt_q, lt_d, zero_q, zero_d, gt_q, gt_d;
  logic [CHUNK-1:0] a_chunk, b_chunk;

  assign a_chunk = a_q[idx_q*CHUNK +: CHUNK];
  assign b_chunk = b_q[idx_q*CHUNK +: CHUNK];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    lt_d    = lt_q;
    zero_d  = zero_q;
    gt_d    = gt_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          // Flipping the sign bit maps two's complement onto offset-binary order.
          a_d = A_in;
          b_d = B_in;
          a_d[WIDTH-1] = A_in[WIDTH-1] ^ ~mode;
          b_d[WIDTH-1] = B_in[WIDTH-1] ^ ~mode;
          idx_d   = IdxLast;
          state_d = StScan;
        end
      end
      StScan: begin
        if (a_chunk < b_chunk) begin
          {lt_d, zero_d, gt_d} = 3'b100;
          state_d = StDone;
        end else if (a_chunk > b_chunk) begin
          {lt_d, zero_d, gt_d} = 3'b001;
          state_d = StDone;
        end else if (idx_q == '0) begin
          {lt_d, zero_d, gt_d} = 3'b010;
          state_d = StDone;
        end else begin
          idx_d = idx_q - IdxW'(1);
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= IdxLast;
      a_q     <= '0;
      b_q     <= '0;
      lt_q    <= 1'b0;
      zero_q  <= 1'b0;
      gt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      lt_q    <= lt_d;
      zero_q  <= zero_d;
      gt_q    <= gt_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign lt        = lt_q;
  assign zero      = zero_q;
  assign gt        = gt_q;

`ifdef SEQ_CMP_MINMAX_EN
  logic             mode_q;
  logic             finish;
  logic [WIDTH-1:0] orig_a, orig_b;
  logic [WIDTH-1:0] min_q, max_q;

  // Undo the sign bias rather than keeping a second copy of each operand.
  always_comb begin
    orig_a = a_q;
    orig_b = b_q;
    orig_a[WIDTH-1] = a_q[WIDTH-1] ^ ~mode_q;
    orig_b[WIDTH-1] = b_q[WIDTH-1] ^ ~mode_q;
  end

  assign finish = (state_q == StScan) && (state_d == StDone);

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= 1'b0;
      min_q  <= '0;
      max_q  <= '0;
    end else begin
      if (state_q == StIdle && in_valid) mode_q <= mode;
      if (finish) begin
        min_q <= gt_d ? orig_b : orig_a;
        max_q <= gt_d ? orig_a : orig_b;
      end
    end
  end

  assign out_min = min_q;
  assign out_max = max_q;
`endif

endmodule

// File: tb/tb_seq_comparator.sv
// Directed bench for seq_comparator: drives 32/8, 64/16 and 32/32 instances with shared operands
// and checks flags, latency, back-pressure hold and reset behaviour.
module tb_seq_comparator;

  logic        clk, rst, in_valid, mode, out_ready;
  logic [63:0] a_bus, b_bus;

  logic in_ready_a, out_valid_a, lt_a, zero_a, gt_a;
  logic in_ready_b, out_valid_b, lt_b, zero_b, gt_b;
  logic in_ready_c, out_valid_c, lt_c, zero_c, gt_c;
`ifdef SEQ_CMP_MINMAX_EN
  logic [31:0] min_a, max_a, min_c, max_c;
  logic [63:0] min_b, max_b;
`endif

  int n_checks = 0;
  int n_errors = 0;

  seq_comparator #(.WIDTH(32), .CHUNK(8)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .A_in(a_bus[31:0]), .B_in(b_bus[31:0]), .mode(mode),
    .out_valid(out_valid_a), .out_ready(out_ready), .lt(lt_a), .zero(zero_a), .gt(gt_a)
`ifdef SEQ_CMP_MINMAX_EN
    , .out_min(min_a), .out_max(max_a)
`endif
  );

  seq_comparator #(.WIDTH(64), .CHUNK(16)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .A_in(a_bus), .B_in(b_bus), .mode(mode),
    .out_valid(out_valid_b), .out_ready(out_ready), .lt(lt_b), .zero(zero_b), .gt(gt_b)
`ifdef SEQ_CMP_MINMAX_EN
    , .out_min(min_b), .out_max(max_b)
`endif
  );

  seq_comparator #(.WIDTH(32), .CHUNK(32)) u_dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_c),
    .A_in(a_bus[31:0]), .B_in(b_bus[31:0]), .mode(mode),
    .out_valid(out_valid_c), .out_ready(out_ready), .lt(lt_c), .zero(zero_c), .gt(gt_c)
`ifdef SEQ_CMP_MINMAX_EN
    , .out_min(min_c), .out_max(max_c)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: direct signed/unsigned magnitude compare, returns {lt, zero, gt}.
  function automatic logic [2:0] ref_flags(input logic [63:0] a, input logic [63:0] b,
                                           input logic m, input int w);
    logic signed [64:0] sa, sb;
    if (w == 32) begin
      sa = m ? $signed({33'd0, a[31:0]}) : $signed({{33{a[31]}}, a[31:0]});
      sb = m ? $signed({33'd0, b[31:0]}) : $signed({{33{b[31]}}, b[31:0]});
    end else begin
      sa = m ? $signed({1'b0, a}) : $signed({a[63], a});
      sb = m ? $signed({1'b0, b}) : $signed({b[63], b});
    end
    if (sa < sb) return 3'b100;
    if (sa == sb) return 3'b010;
    return 3'b001;
  endfunction

  // Latency = 1 + (n-1-j) for highest differing chunk j, n when equal.
  function automatic int ref_lat(input logic [63:0] a, input logic [63:0] b,
                                 input int w, input int c);
    logic [63:0] x;
    int n;
    x = a ^ b;
    if (w == 32) x[63:32] = '0;
    n = w / c;
    for (int j = n - 1; j >= 0; j--) begin
      if (((x >> (j * c)) & ((64'd1 << c) - 64'd1)) != 64'd0) return n - j;
    end
    return n;
  endfunction

  task automatic run_vec(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input logic m, input logic [2:0] ef_a, input int el_a);
    logic [2:0] ef_b, ef_c;
    int el_b, el_c, la, lb, lc;
    ef_b = ref_flags(a, b, m, 64);
    ef_c = ref_flags(a, b, m, 32);
    el_b = ref_lat(a, b, 64, 16);
    el_c = ref_lat(a, b, 32, 32);
    la = 0; lb = 0; lc = 0;
    a_bus = a; b_bus = b; mode = m; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Scramble inputs during the scan; captured operands must be used.
    a_bus = ~a; b_bus = a; mode = ~m;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(posedge clk); #1;
      if (out_valid_a && la == 0) begin
        la = cyc;
        check({tag, " flags_a_first"}, {61'd0, lt_a, zero_a, gt_a}, {61'd0, ef_a});
      end
      if (out_valid_b && lb == 0) lb = cyc;
      if (out_valid_c && lc == 0) lc = cyc;
    end
    // Results held under out_ready=0 for several cycles.
    check({tag, " lat_a"}, 64'(la), 64'(el_a));
    check({tag, " lat_b"}, 64'(lb), 64'(el_b));
    check({tag, " lat_c"}, 64'(lc), 64'(el_c));
    check({tag, " hold_a"}, {61'd0, lt_a, zero_a, gt_a}, {61'd0, ef_a});
    check({tag, " hold_b"}, {61'd0, lt_b, zero_b, gt_b}, {61'd0, ef_b});
    check({tag, " hold_c"}, {61'd0, lt_c, zero_c, gt_c}, {61'd0, ef_c});
    check({tag, " busy"}, {61'd0, in_ready_a, in_ready_b, in_ready_c}, 64'd0);
    check({tag, " valid"}, {61'd0, out_valid_a, out_valid_b, out_valid_c}, 64'd7);
`ifdef SEQ_CMP_MINMAX_EN
    check({tag, " min_a"}, {32'd0, min_a}, {32'd0, ef_a[0] ? b[31:0] : a[31:0]});
    check({tag, " max_a"}, {32'd0, max_a}, {32'd0, ef_a[0] ? a[31:0] : b[31:0]});
    check({tag, " min_b"}, min_b, ef_b[0] ? b : a);
    check({tag, " max_b"}, max_b, ef_b[0] ? a : b);
    check({tag, " min_c"}, {32'd0, min_c}, {32'd0, ef_c[0] ? b[31:0] : a[31:0]});
`endif
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " idle"}, {61'd0, in_ready_a, in_ready_b, in_ready_c}, 64'd7);
    check({tag, " released"}, {61'd0, out_valid_a, out_valid_b, out_valid_c}, 64'd0);
  endtask

  initial begin
    logic [63:0] ra, rb;
    logic        rm;
    rst = 1'b1; in_valid = 1'b0; mode = 1'b1; out_ready = 1'b0;
    a_bus = '0; b_bus = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_ready", {61'd0, in_ready_a, in_ready_b, in_ready_c}, 64'd7);
    check("reset_valid", {61'd0, out_valid_a, out_valid_b, out_valid_c}, 64'd0);
    check("reset_flags_a", {61'd0, lt_a, zero_a, gt_a}, 64'd0);
`ifdef SEQ_CMP_MINMAX_EN
    check("reset_minmax_b", min_b | max_b, 64'd0);
`endif

    run_vec("eq5",      64'd5,                  64'd5,                  1'b1, 3'b010, 4);
    run_vec("msb_s",    64'h0000_0000_8000_0000, 64'h1,                 1'b0, 3'b100, 1);
    run_vec("msb_u",    64'h0000_0000_8000_0000, 64'h1,                 1'b1, 3'b001, 1);
    run_vec("mid_u",    64'h1200,               64'h1300,               1'b1, 3'b100, 3);
    run_vec("neg1",     64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 3'b001, 4);
    run_vec("max_min_s", 64'h7FFF_FFFF,         64'h8000_0000,          1'b0, 3'b001, 1);
    run_vec("max_min_u", 64'h7FFF_FFFF,         64'h8000_0000,          1'b1, 3'b100, 1);
    run_vec("byte2",    64'h0001_0000,          64'h0000_FFFF,          1'b0, 3'b001, 2);
    run_vec("neg_lo",   64'h1234_5678_FFFF_FF00, 64'h1234_5678_FFFF_FF7F, 1'b0, 3'b100, 4);

    for (int i = 0; i < 6; i++) begin
      ra = {$urandom, $urandom};
      rb = (i % 2 == 0) ? {$urandom, $urandom} : ra ^ (64'd1 << $urandom_range(0, 63));
      rm = 1'(i % 3 == 0);
      run_vec($sformatf("rnd%0d", i), ra, rb, rm, ref_flags(ra, rb, rm, 32),
              ref_lat(ra, rb, 32, 8));
    end

    // Reset on the second scan cycle of an equal-operand compare; 32/32 is already in DONE.
    a_bus = 64'd5; b_bus = 64'd5; mode = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_valid", {61'd0, out_valid_a, out_valid_b, out_valid_c}, 64'd0);
    check("rst_mid_ready", {61'd0, in_ready_a, in_ready_b, in_ready_c}, 64'd7);
    check("rst_mid_flags_a", {61'd0, lt_a, zero_a, gt_a}, 64'd0);
    check("rst_mid_flags_c", {61'd0, lt_c, zero_c, gt_c}, 64'd0);
    repeat (6) @(posedge clk);
    #1;
    check("rst_no_stale", {61'd0, out_valid_a, out_valid_b, out_valid_c}, 64'd0);
    run_vec("post_rst", 64'h0000_0000_0000_00A0, 64'h0000_0000_0000_00A1, 1'b1, 3'b100, 4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
